// File: rtl/cvxif_pkg.sv
// ============================================================================
// Module : cvxif_pkg
// Brief  : Shared types and constants for the CVXIF result buffer slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cvxif_pkg;

  localparam int XLEN = 32;
  localparam int ID_W = 4;
  localparam int DEPTH_DEFAULT = 4;

  // Opcode decoded by the issue stage for posit coprocessor instructions.
  localparam logic [6:0] CUSTOM3_OPCODE = 7'b1111011;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W = $clog2(DEPTH_DEFAULT) + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] data;
    logic            done;
  } result_entry_t;

endpackage

`default_nettype wire

// File: rtl/cvxif_result_buffer_if.sv
// ============================================================================
// Module : cvxif_result_buffer_if
// Brief  : Issue, coprocessor-result and core-result signals of the buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cvxif_result_buffer_if #(
  parameter int ID_W = cvxif_pkg::ID_W,
  parameter int XLEN = cvxif_pkg::XLEN
) ();
  import cvxif_pkg::*;

  logic            issue_fire;
  logic [4:0]      issue_rd;
  logic [ID_W-1:0] issue_id;
  logic            tag_full;
  logic            cp_result_valid;
  logic            cp_result_ready;
  logic [XLEN-1:0] cp_result_data;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result_data;
  logic [4:0]      result_rd;
  logic [ID_W-1:0] result_id;
  logic            result_we;
  logic            overflow_err;

  modport slave (
    input  issue_fire, issue_rd, issue_id,
    input  cp_result_valid, cp_result_data,
    input  result_ready,
    output tag_full, cp_result_ready,
    output result_valid, result_data, result_rd, result_id, result_we,
    output overflow_err
  );

  modport master (
    output issue_fire, issue_rd, issue_id,
    output cp_result_valid, cp_result_data,
    output result_ready,
    input  tag_full, cp_result_ready,
    input  result_valid, result_data, result_rd, result_id, result_we,
    input  overflow_err
  );

endinterface

`default_nettype wire

// File: rtl/cvxif_ring_ptr.sv
// ============================================================================
// Module : cvxif_ring_ptr
// Brief  : Wrap-bit ring pointer with increment enable, async active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cvxif_ring_ptr #(
  parameter int PTR_W = cvxif_pkg::PTR_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  output logic      [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  // Natural overflow of the full width gives the modulo 2*DEPTH roll.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/cvxif_result_buffer.sv
// ============================================================================
// Module : cvxif_result_buffer
// Brief  : In-order CVXIF result buffer between posit coprocessor and core.
//          Optional same-cycle bypass: define CVXIF_RESULT_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cvxif_result_buffer #(
  parameter int DEPTH = cvxif_pkg::DEPTH_DEFAULT,
  parameter int ID_W  = cvxif_pkg::ID_W,
  parameter int XLEN  = cvxif_pkg::XLEN
) (
  input  wire logic             clk,
  input  wire logic             rst,
  cvxif_result_buffer_if.slave  bus
);
  import cvxif_pkg::*;

  localparam int AW = ptr_width(DEPTH);
  localparam int IW = AW - 1;
  localparam logic [AW-1:0] c_full_occ = AW'(DEPTH);

  logic [AW-1:0]   w_alloc_ptr;
  logic [AW-1:0]   w_fill_ptr;
  logic [AW-1:0]   w_rd_ptr;
  logic [IW-1:0]   w_alloc_idx;
  logic [IW-1:0]   w_fill_idx;
  logic [IW-1:0]   w_rd_idx;
  logic [AW-1:0]   w_occ;
  logic            w_tag_full;
  logic            w_cp_ready;
  logic            w_alloc_en;
  logic            w_fill_en;
  logic            w_set_done;
  logic            w_head_avail;
  logic            w_out_valid;
  logic [XLEN-1:0] w_out_data;
  logic            w_pop_en;

  logic [4:0]      r_rd   [DEPTH];
  logic [ID_W-1:0] r_id   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_done;
  logic            r_overflow;

  cvxif_ring_ptr #(.PTR_W(AW)) u_alloc_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_alloc_en),
    .o_ptr (w_alloc_ptr)
  );

  cvxif_ring_ptr #(.PTR_W(AW)) u_fill_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_fill_en),
    .o_ptr (w_fill_ptr)
  );

  cvxif_ring_ptr #(.PTR_W(AW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop_en),
    .o_ptr (w_rd_ptr)
  );

  assign w_alloc_idx = w_alloc_ptr[IW-1:0];
  assign w_fill_idx  = w_fill_ptr[IW-1:0];
  assign w_rd_idx    = w_rd_ptr[IW-1:0];

  assign w_occ      = w_alloc_ptr - w_rd_ptr;
  assign w_tag_full = (w_occ == c_full_occ);
  assign w_cp_ready = (w_fill_ptr != w_alloc_ptr);
  assign w_alloc_en = bus.issue_fire & ~w_tag_full;
  assign w_fill_en  = bus.cp_result_valid & w_cp_ready;

  assign w_head_avail = (w_rd_ptr != w_alloc_ptr) & r_done[w_rd_idx];

`ifdef CVXIF_RESULT_BYPASS_EN
  // Head still waiting on data that is arriving right now: forward it.
  logic w_bypass;
  assign w_bypass    = (w_rd_ptr == w_fill_ptr) & w_fill_en;
  assign w_out_valid = w_head_avail | w_bypass;
  assign w_out_data  = w_bypass ? bus.cp_result_data : r_data[w_rd_idx];
  assign w_set_done  = w_fill_en & ~(w_bypass & bus.result_ready);
`else
  assign w_out_valid = w_head_avail;
  assign w_out_data  = r_data[w_rd_idx];
  assign w_set_done  = w_fill_en;
`endif

  assign w_pop_en = w_out_valid & bus.result_ready;

  // Alloc, fill and pop indices never collide within a cycle, so the
  // three updates to r_done below touch distinct entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_id[i]   <= '0;
        r_data[i] <= '0;
      end
      r_done     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_alloc_en) begin
        r_rd[w_alloc_idx]   <= bus.issue_rd;
        r_id[w_alloc_idx]   <= bus.issue_id;
        r_done[w_alloc_idx] <= 1'b0;
      end
      if (w_set_done) begin
        r_data[w_fill_idx] <= bus.cp_result_data;
        r_done[w_fill_idx] <= 1'b1;
      end
      if (w_pop_en) begin
        r_done[w_rd_idx] <= 1'b0;
      end
      if (bus.issue_fire & w_tag_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.tag_full        = w_tag_full;
  assign bus.cp_result_ready = w_cp_ready;
  assign bus.result_valid    = w_out_valid;
  assign bus.result_we       = w_out_valid;
  assign bus.result_data     = w_out_valid ? w_out_data       : '0;
  assign bus.result_rd       = w_out_valid ? r_rd[w_rd_idx]   : '0;
  assign bus.result_id       = w_out_valid ? r_id[w_rd_idx]   : '0;
  assign bus.overflow_err    = r_overflow;

endmodule

`default_nettype wire
